cfg_serial_loader: RTL and testbench

CFG_SERIAL_LOADER -- requirements
Module: cfg_serial_loader

---
 rtl/cfg_serial_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_cfg_serial_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_serial_loader.sv
// Serial-to-parallel synth configuration loader with mode-0 host framing.
// Optional readback of shadowed bytes on miso: CFG_LOADER_READBACK_EN.
module cfg_serial_loader #(
   parameter int NUM_BYTES   = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       cs_n,
   input  logic       mosi,
   output logic [7:0] cfg_data,
   output logic [7:0] cfg_we,
   output logic       miso,
   output logic       busy,
   output logic       frame_err
);

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      DATA,
      ERROR
   } state_t;

   localparam logic [2:0] LAST_PTR = 3'(NUM_BYTES - 1);
   localparam logic [3:0] NUM_B4   = 4'(NUM_BYTES);

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_dly_q, sclk_dly_d;
   logic                   cs_dly_q, cs_dly_d;

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] ptr_q, ptr_d;
   logic       wr_q, wr_d;
   logic       err_q, err_d;
   logic [7:0] cfg_data_q, cfg_data_d;
   logic [7:0] cfg_we_q, cfg_we_d;

`ifdef CFG_LOADER_READBACK_EN
   logic [7:0] shadow_q [NUM_BYTES];
   logic [7:0] shadow_d [NUM_BYTES];
   logic [7:0] rd_q, rd_d;
   logic       sclk_fall;
`endif

   logic       sclk_s;
   logic       cs_s;
   logic       mosi_s;
   logic       sclk_rise;
   logic       cs_fall;
   logic       cs_rise;
   logic       byte_done;
   logic [7:0] byte_next;
   logic [2:0] hdr_addr;
   logic       addr_bad;
   logic [2:0] ptr_inc;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign cs_fall   = ~cs_s & cs_dly_q;
   assign cs_rise   = cs_s & ~cs_dly_q;
   assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
   assign byte_next = {shift_q[6:0], mosi_s};
   assign hdr_addr  = byte_next[2:0];
   assign addr_bad  = ({1'b0, hdr_addr} >= NUM_B4);
   assign ptr_inc   = (ptr_q == LAST_PTR) ? 3'd0 : ptr_q + 3'd1;

`ifdef CFG_LOADER_READBACK_EN
   assign sclk_fall = ~sclk_s & sclk_dly_q;
`endif

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_dly_d  = sclk_s;
      cs_dly_d    = cs_s;

      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      wr_d       = wr_q;
      err_d      = err_q;
      cfg_data_d = cfg_data_q;
      cfg_we_d   = 8'h00;
`ifdef CFG_LOADER_READBACK_EN
      rd_d     = rd_q;
      shadow_d = shadow_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d   = HEADER;
               bit_cnt_d = 3'd0;
               shift_d   = 8'h00;
               err_d     = 1'b0;
`ifdef CFG_LOADER_READBACK_EN
               rd_d = 8'h00;
`endif
            end
         end
         HEADER: begin
            if (sclk_rise) begin
               shift_d   = byte_next;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (byte_done) begin
                  ptr_d = hdr_addr;
                  wr_d  = byte_next[7];
                  if (addr_bad) begin
                     state_d = ERROR;
                     err_d   = 1'b1;
                  end else if (byte_next[7]) begin
                     state_d = DATA;
                  end else begin
`ifdef CFG_LOADER_READBACK_EN
                     state_d = DATA;
                     rd_d    = shadow_q[hdr_addr];
`else
                     state_d = ERROR;
                     err_d   = 1'b1;
`endif
                  end
               end
            end
         end
         DATA: begin
            if (sclk_rise) begin
               shift_d   = byte_next;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (byte_done) begin
                  ptr_d = ptr_inc;
                  if (wr_q) begin
                     cfg_data_d = byte_next;
                     cfg_we_d   = 8'd1 << ptr_q;
`ifdef CFG_LOADER_READBACK_EN
                     shadow_d[ptr_q] = byte_next;
`endif
                  end
               end
            end
`ifdef CFG_LOADER_READBACK_EN
            // first fall of each byte reloads from the (already advanced) pointer
            if (!wr_q && sclk_fall) begin
               if (bit_cnt_q == 3'd0) rd_d = shadow_q[ptr_q];
               else                   rd_d = {rd_q[6:0], 1'b0};
            end
`endif
         end
         ERROR: begin
         end
      endcase

      // a completing byte is still written when cs_n rises in the same cycle
      if (cs_rise && (state_q != IDLE)) begin
         state_d = IDLE;
`ifdef CFG_LOADER_READBACK_EN
         rd_d = 8'h00;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_dly_q  <= 1'b0;
         cs_dly_q    <= 1'b0;
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         ptr_q       <= 3'd0;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         cfg_data_q  <= 8'h00;
         cfg_we_q    <= 8'h00;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_dly_q  <= sclk_dly_d;
         cs_dly_q    <= cs_dly_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         wr_q        <= wr_d;
         err_q       <= err_d;
         cfg_data_q  <= cfg_data_d;
         cfg_we_q    <= cfg_we_d;
      end
   end

`ifdef CFG_LOADER_READBACK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= 8'h00;
         for (int i = 0; i < NUM_BYTES; i++) shadow_q[i] <= 8'h00;
      end else begin
         rd_q     <= rd_d;
         shadow_q <= shadow_d;
      end
   end

   assign miso = rd_q[7];
`else
   assign miso = 1'b0;
`endif

   assign cfg_data  = cfg_data_q;
   assign cfg_we    = cfg_we_q;
   assign busy      = (state_q != IDLE);
   assign frame_err = err_q;

endmodule

// File: tb/tb_cfg_serial_loader.sv
// Directed bench for cfg_serial_loader: framing, writes, wrap, errors, reset.
// Define CFG_LOADER_READBACK_EN for both files to exercise miso readback.
module tb_cfg_serial_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic [7:0] cfg_data;
   logic [7:0] cfg_we;
   logic       miso;
   logic       busy;
   logic       frame_err;

   int total = 0;
   int bad = 0;

   logic [7:0] we_log [16];
   logic [7:0] data_log [16];
   int         lat_log [16];
   int         n_we = 0;
   time        last_rise_t = 0;

   cfg_serial_loader #(
      .NUM_BYTES(6),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sclk(sclk),
      .cs_n(cs_n),
      .mosi(mosi),
      .cfg_data(cfg_data),
      .cfg_we(cfg_we),
      .miso(miso),
      .busy(busy),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && cfg_we != 8'h00) begin
         if (n_we < 16) begin
            we_log[n_we]   = cfg_we;
            data_log[n_we] = cfg_data;
            lat_log[n_we]  = int'($time - last_rise_t);
         end
         n_we++;
      end
   end

   task automatic send_bits(input logic [7:0] b, input int nb, input int half);
      for (int i = 7; i > 7 - nb; i--) begin
         mosi = b[i];
         #half;
         sclk = 1'b1;
         last_rise_t = $time;
         #half;
         sclk = 1'b0;
      end
   endtask

   task automatic frame_begin();
      cs_n = 1'b0;
      #40;
   endtask

   task automatic frame_end();
      #40;
      cs_n = 1'b1;
      #80;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++; if (cfg_data !== 8'h00) begin bad++; $display("FAIL rst_cfg_data got=%h exp=00", cfg_data); end
      total++; if (cfg_we !== 8'h00) begin bad++; $display("FAIL rst_cfg_we got=%h exp=00", cfg_we); end
      total++; if (miso !== 1'b0) begin bad++; $display("FAIL rst_miso got=%b exp=0", miso); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_write_basic();
      n_we = 0;
      frame_begin();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy_hi got=%b exp=1", busy); end
      send_bits(8'h80, 8, 20);
      send_bits(8'h38, 8, 20);
      send_bits(8'h03, 8, 20);
      frame_end();
      total++; if (n_we !== 2) begin bad++; $display("FAIL wr_count got=%0d exp=2", n_we); end
      total++; if (we_log[0] !== 8'h01 || data_log[0] !== 8'h38) begin
         bad++; $display("FAIL wr_first got=%h/%h exp=01/38", we_log[0], data_log[0]); end
      total++; if (we_log[1] !== 8'h02 || data_log[1] !== 8'h03) begin
         bad++; $display("FAIL wr_second got=%h/%h exp=02/03", we_log[1], data_log[1]); end
      total++; if (lat_log[0] > 40) begin bad++; $display("FAIL wr_latency got=%0d exp<=40", lat_log[0]); end
      total++; if (cfg_data !== 8'h03) begin bad++; $display("FAIL wr_hold got=%h exp=03", cfg_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_lo got=%b exp=0", busy); end
   endtask

   task automatic test_wrap();
      n_we = 0;
      frame_begin();
      send_bits(8'h85, 8, 20);
      send_bits(8'hAA, 8, 20);
      send_bits(8'hBB, 8, 20);
      send_bits(8'hCC, 8, 20);
      frame_end();
      total++; if (n_we !== 3) begin bad++; $display("FAIL wrap_count got=%0d exp=3", n_we); end
      total++; if (we_log[0] !== 8'h20 || data_log[0] !== 8'hAA) begin
         bad++; $display("FAIL wrap_b0 got=%h/%h exp=20/aa", we_log[0], data_log[0]); end
      total++; if (we_log[1] !== 8'h01 || data_log[1] !== 8'hBB) begin
         bad++; $display("FAIL wrap_b1 got=%h/%h exp=01/bb", we_log[1], data_log[1]); end
      total++; if (we_log[2] !== 8'h02 || data_log[2] !== 8'hCC) begin
         bad++; $display("FAIL wrap_b2 got=%h/%h exp=02/cc", we_log[2], data_log[2]); end
   endtask

   task automatic test_bad_addr();
      n_we = 0;
      frame_begin();
      send_bits(8'h86, 8, 20);
      send_bits(8'h11, 8, 20);
      #40;
      total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL bad_err_mid got=%b exp=1", frame_err); end
      frame_end();
      total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL bad_err_sticky got=%b exp=1", frame_err); end
      total++; if (n_we !== 0) begin bad++; $display("FAIL bad_no_we got=%0d exp=0", n_we); end
      frame_begin();
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL bad_err_clr got=%b exp=0", frame_err); end
      send_bits(8'h83, 8, 20);
      send_bits(8'h44, 8, 20);
      frame_end();
      total++; if (n_we !== 1 || we_log[0] !== 8'h08 || data_log[0] !== 8'h44) begin
         bad++; $display("FAIL bad_next got=%0d:%h/%h exp=1:08/44", n_we, we_log[0], data_log[0]); end
   endtask

   task automatic test_abort();
      n_we = 0;
      frame_begin();
      send_bits(8'h80, 8, 20);
      send_bits(8'h55, 5, 20);
      frame_end();
      total++; if (n_we !== 0) begin bad++; $display("FAIL abort_no_we got=%0d exp=0", n_we); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
      frame_begin();
      send_bits(8'h84, 8, 20);
      send_bits(8'h99, 8, 20);
      frame_end();
      total++; if (n_we !== 1 || we_log[0] !== 8'h10 || data_log[0] !== 8'h99) begin
         bad++; $display("FAIL abort_next got=%0d:%h/%h exp=1:10/99", n_we, we_log[0], data_log[0]); end
   endtask

   task automatic test_edge_coincide();
      n_we = 0;
      frame_begin();
      send_bits(8'h80, 8, 20);
      send_bits(8'h6C, 7, 20);
      mosi = 1'b0;
      #20;
      sclk = 1'b1;
      cs_n = 1'b1;
      last_rise_t = $time;
      #20;
      sclk = 1'b0;
      #80;
      total++; if (n_we !== 1 || we_log[0] !== 8'h01 || data_log[0] !== 8'h6C) begin
         bad++; $display("FAIL coincide got=%0d:%h/%h exp=1:01/6c", n_we, we_log[0], data_log[0]); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL coincide_busy got=%b exp=0", busy); end
   endtask

   task automatic test_async_reset();
      n_we = 0;
      frame_begin();
      send_bits(8'h87, 8, 20);
      send_bits(8'hF0, 4, 20);
      total++; if (frame_err !== 1'b1 || busy !== 1'b1) begin
         bad++; $display("FAIL ar_pre got=%b%b exp=11", frame_err, busy); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (cfg_data !== 8'h00) begin bad++; $display("FAIL ar_cfg_data got=%h exp=00", cfg_data); end
      total++; if (busy !== 1'b0 || frame_err !== 1'b0) begin
         bad++; $display("FAIL ar_flags got=%b%b exp=00", busy, frame_err); end
      total++; if (cfg_we !== 8'h00 || miso !== 1'b0) begin
         bad++; $display("FAIL ar_we_miso got=%h/%b exp=00/0", cfg_we, miso); end
      @(negedge clk);
      rst_n = 1'b1;
      send_bits(8'h0F, 4, 20);
      send_bits(8'h80, 8, 20);
      send_bits(8'h12, 8, 20);
      #40;
      total++; if (n_we !== 0 || busy !== 1'b0) begin
         bad++; $display("FAIL ar_held_low got=%0d/%b exp=0/0", n_we, busy); end
      cs_n = 1'b1;
      #80;
      frame_begin();
      send_bits(8'h80, 8, 20);
      send_bits(8'h21, 8, 20);
      frame_end();
      total++; if (n_we !== 1 || we_log[0] !== 8'h01 || data_log[0] !== 8'h21) begin
         bad++; $display("FAIL ar_next got=%0d:%h/%h exp=1:01/21", n_we, we_log[0], data_log[0]); end
   endtask

   task automatic test_readback();
      logic [7:0] got;
      got = 8'h00;
`ifdef CFG_LOADER_READBACK_EN
      n_we = 0;
      frame_begin();
      send_bits(8'h82, 8, 20);
      send_bits(8'h5A, 8, 20);
      frame_end();
      total++; if (n_we !== 1 || we_log[0] !== 8'h04) begin
         bad++; $display("FAIL rb_write got=%0d:%h exp=1:04", n_we, we_log[0]); end
`endif
      cs_n = 1'b0;
      #120;
      send_bits(8'h02, 8, 60);
      for (int i = 7; i >= 0; i--) begin
         mosi = 1'b0;
         #60;
         got[i] = miso;
         sclk = 1'b1;
         #60;
         sclk = 1'b0;
      end
`ifdef CFG_LOADER_READBACK_EN
      total++; if (got !== 8'h5A) begin bad++; $display("FAIL rb_miso got=%h exp=5a", got); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rb_err got=%b exp=0", frame_err); end
`else
      total++; if (got !== 8'h00) begin bad++; $display("FAIL rb_miso got=%h exp=00", got); end
      total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL rb_err got=%b exp=1", frame_err); end
`endif
      frame_end();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rb_busy got=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_wrap();
      test_bad_addr();
      test_abort();
      test_edge_coincide();
      test_async_reset();
      test_readback();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
